// File: rtl/dsam_decoder.sv
// DSAM decoder: undoes the XOR chain and the CHANNELS-distance difference.
// Define DSAM_DECODER_SYNC_CLEAR_EN to add a synchronous stream-restart input.
module dsam_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef DSAM_DECODER_SYNC_CLEAR_EN
  input  logic                  clear,
`endif
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CHANNELS - 1);

  logic [W-1:0]  hist [CHANNELS];
  logic [PW-1:0] ptr;
  logic          warm;
  logic [W-2:0]  c_prev;
  logic [W-2:0]  m;
  logic [W-2:0]  low;
  logic [W-1:0]  d;
  logic [W-1:0]  x;
  logic          accept;
  logic          xfer;
  logic          flush;
  logic          wrap;

`ifdef DSAM_DECODER_SYNC_CLEAR_EN
  assign flush = clear;
`else
  assign flush = 1'b0;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign wrap     = (ptr == LAST);

  // During warm-up the history slot is unwritten, so d passes straight out
  always_comb begin
    m   = in[W-2:0] ^ c_prev;
    low = in[W-1] ? ~m : m;
    d   = {in[W-1], low};
    x   = warm ? (hist[ptr] - d) : d;
  end

  always_ff @(posedge clk) begin
    if (accept && !flush)
      hist[ptr] <= x;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      c_prev    <= '0;
      ptr       <= '0;
      warm      <= 1'b0;
    end else if (flush) begin
      out       <= '0;
      out_valid <= 1'b0;
      c_prev    <= '0;
      ptr       <= '0;
      warm      <= 1'b0;
    end else if (accept) begin
      out       <= x;
      out_valid <= 1'b1;
      c_prev    <= in[W-2:0];
      ptr       <= wrap ? '0 : ptr + PW'(1);
      if (wrap)
        warm <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsam_decoder.sv
// Bench for dsam_decoder: directed cases plus randomized streams
// checked against a behavioural DSAM encoder model.
module tb_dsam_decoder;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [15:0] din  [2];
  logic [15:0] dout [2];
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];

  int total;
  int bad;

  logic [15:0] mhist [$];
  logic [14:0] mc;
  int          mch;

  dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4)) dut4 (
    .clk(clk), .reset(rst_n),
`ifdef DSAM_DECODER_SYNC_CLEAR_EN
    .clear(clear),
`endif
    .in(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0])
  );

  dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(1)) dut1 (
    .clk(clk), .reset(rst_n),
`ifdef DSAM_DECODER_SYNC_CLEAR_EN
    .clear(clear),
`endif
    .in(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset(input int ch);
    mhist.delete();
    mc  = '0;
    mch = ch;
  endfunction

  // Encode x as the next sample of the stream without committing it
  function automatic logic [15:0] enc(input logic [15:0] x);
    logic [15:0] d;
    logic [14:0] m;
    int n;
    n = mhist.size();
    if (n < mch) d = x;
    else d = mhist[n-mch] - x;
    m = d[15] ? ~d[14:0] : d[14:0];
    return {d[15], m ^ mc};
  endfunction

  function automatic void commit(input logic [15:0] x);
    logic [15:0] e;
    e = enc(x);
    mc = e[14:0];
    mhist.push_back(x);
  endfunction

  task automatic do_reset(input int ch);
    @(negedge clk);
    rst_n = 1'b0;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset(ch);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    total++;
    if (ov[0] !== 1'b0 || dout[0] !== 16'h0) begin
      bad++;
      $display("FAIL reset_c4: out=%h valid=%b required out=0000 valid=0", dout[0], ov[0]);
    end
    total++;
    if (ov[1] !== 1'b0 || dout[1] !== 16'h0) begin
      bad++;
      $display("FAIL reset_c1: out=%h valid=%b required out=0000 valid=0", dout[1], ov[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b0;
    #1;
    total++;
    if (ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b required 1", ir[0]);
    end
    ordy[0] = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] es [5];
    logic [15:0] xs [5];
    es = '{16'h0005, 16'h0006, 16'h000F, 16'h000E, 16'h800F};
    xs = '{16'h0005, 16'h0003, 16'h0009, 16'h0001, 16'h0007};
    do_reset(4);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        total++;
        if (ov[0] !== 1'b1 || dout[0] !== xs[i-1]) begin
          bad++;
          $display("FAIL basic[%0d]: out=%h valid=%b required out=%h valid=1",
                   i - 1, dout[0], ov[0], xs[i-1]);
        end
      end
      if (i < 5) begin
        din[0] = es[i];
        iv[0]  = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
    end
  endtask

  task automatic test_stall;
    logic [15:0] x0, x1, x2;
    do_reset(4);
    x0 = 16'($urandom);
    x1 = 16'($urandom);
    x2 = 16'($urandom);
    @(negedge clk);
    din[0] = enc(x0);
    commit(x0);
    iv[0] = 1'b1;
    ordy[0] = 1'b0;
    #1;
    total++;
    if (ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL stall_empty_ready: in_ready=%b required 1", ir[0]);
    end
    @(negedge clk);
    din[0] = enc(x1);
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (ov[0] !== 1'b1 || dout[0] !== x0 || ir[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: out=%h valid=%b ready=%b required out=%h valid=1 ready=0",
                 k, dout[0], ov[0], ir[0], x0);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    #1;
    total++;
    if (ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_ready: in_ready=%b required 1", ir[0]);
    end
    commit(x1);
    @(negedge clk);
    #1;
    total++;
    if (ov[0] !== 1'b1 || dout[0] !== x1) begin
      bad++;
      $display("FAIL stall_next: out=%h valid=%b required out=%h valid=1", dout[0], ov[0], x1);
    end
    din[0] = enc(x2);
    commit(x2);
    @(negedge clk);
    #1;
    total++;
    if (ov[0] !== 1'b1 || dout[0] !== x2) begin
      bad++;
      $display("FAIL stall_chain: out=%h valid=%b required out=%h valid=1", dout[0], ov[0], x2);
    end
    iv[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] xs [6];
    do_reset(4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      xs[i] = 16'($urandom);
      din[0] = enc(xs[i]);
      commit(xs[i]);
      iv[0] = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    din[0] = 16'($urandom);
    #1;
    total++;
    if (ov[0] !== 1'b0 || dout[0] !== 16'h0) begin
      bad++;
      $display("FAIL midreset_async: out=%h valid=%b required out=0000 valid=0", dout[0], ov[0]);
    end
    @(negedge clk);
    #1;
    total++;
    if (ov[0] !== 1'b0 || dout[0] !== 16'h0) begin
      bad++;
      $display("FAIL midreset_hold: out=%h valid=%b required out=0000 valid=0", dout[0], ov[0]);
    end
    rst_n = 1'b1;
    iv[0] = 1'b0;
    model_reset(4);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        total++;
        if (ov[0] !== 1'b1 || dout[0] !== xs[i-1]) begin
          bad++;
          $display("FAIL midreset_restart[%0d]: out=%h valid=%b required out=%h valid=1",
                   i - 1, dout[0], ov[0], xs[i-1]);
        end
      end
      if (i < 6) begin
        xs[i] = 16'($urandom);
        din[0] = enc(xs[i]);
        commit(xs[i]);
        iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
    end
  endtask

`ifdef DSAM_DECODER_SYNC_CLEAR_EN
  task automatic test_clear;
    logic [15:0] xs [6];
    do_reset(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      xs[i] = 16'($urandom);
      din[0] = enc(xs[i]);
      commit(xs[i]);
      iv[0] = 1'b1;
    end
    @(negedge clk);
    din[0] = enc(16'($urandom));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    iv[0] = 1'b0;
    #1;
    total++;
    if (ov[0] !== 1'b0 || dout[0] !== 16'h0) begin
      bad++;
      $display("FAIL clear_discard: out=%h valid=%b required out=0000 valid=0", dout[0], ov[0]);
    end
    model_reset(4);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        total++;
        if (ov[0] !== 1'b1 || dout[0] !== xs[i-1]) begin
          bad++;
          $display("FAIL clear_restart[%0d]: out=%h valid=%b required out=%h valid=1",
                   i - 1, dout[0], ov[0], xs[i-1]);
        end
      end
      if (i < 6) begin
        xs[i] = 16'($urandom);
        din[0] = enc(xs[i]);
        commit(xs[i]);
        iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
    end
  endtask
`endif

  task automatic test_random(input int ch, input int nsamp);
    logic [15:0] expq [$];
    logic [15:0] cx, ce, pout, want;
    bit have, pstall;
    int sent, got, cyc;
    do_reset(ch == 0 ? 4 : 1);
    have = 0;
    pstall = 0;
    sent = 0;
    got = 0;
    cyc = 0;
    cx = '0;
    ce = '0;
    pout = '0;
    while (got < nsamp && cyc < 20 * nsamp) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < nsamp) begin
        cx = 16'($urandom);
        ce = enc(cx);
        have = 1;
      end
      din[ch]  = ce;
      iv[ch]   = have && ($urandom_range(0, 3) != 0);
      ordy[ch] = ($urandom_range(0, 2) != 0);
      #1;
      if (pstall) begin
        total++;
        if (ov[ch] !== 1'b1 || dout[ch] !== pout) begin
          bad++;
          $display("FAIL rand_stable ch%0d: out=%h valid=%b required out=%h valid=1",
                   ch, dout[ch], ov[ch], pout);
        end
      end
      if (ov[ch] && ordy[ch]) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL rand_extra ch%0d: out=%h required no output", ch, dout[ch]);
        end else begin
          want = expq.pop_front();
          if (dout[ch] !== want) begin
            bad++;
            $display("FAIL rand_data ch%0d #%0d: out=%h required %h", ch, got, dout[ch], want);
          end
        end
        got++;
      end
      pstall = ov[ch] && !ordy[ch];
      pout = dout[ch];
      if (iv[ch] && ir[ch]) begin
        commit(cx);
        expq.push_back(cx);
        sent++;
        have = 0;
      end
    end
    @(negedge clk);
    iv[ch] = 1'b0;
    ordy[ch] = 1'b1;
    #1;
    total++;
    if (got != nsamp || expq.size() != 0 || ov[ch] !== 1'b0) begin
      bad++;
      $display("FAIL rand_count ch%0d: got=%0d pending=%0d valid=%b required got=%0d pending=0 valid=0",
               ch, got, expq.size(), ov[ch], nsamp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0;
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    model_reset(4);
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
`ifdef DSAM_DECODER_SYNC_CLEAR_EN
    test_clear();
`endif
    test_random(0, 1000);
    test_random(1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
